// File: rtl/morse_tx_encoder.sv
// Morse transmitter: one ASCII character per handshake, played out as a key waveform
// with standard unit timing (dot 1U, dash 3U, element gap 1U, letter gap 3U, space 4U).
module morse_tx_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [31:0] unit_cycles,
  input  logic        abort,
  output logic        key_out,
  output logic        dot_pulse,
  output logic        dash_pulse,
  output logic        done,
  output logic        bad_char
);

  typedef enum logic [2:0] {StIdle, StMark, StEgap, StLgap, StWord, StBad} state_e;

  state_e      state;
  logic [33:0] cnt;
  logic [33:0] unit;
  logic [4:0]  pat;
  logic [2:0]  left;

  // Returns {length, pattern}; pattern right-aligned, first element in the MSB of the
  // used field, 1 = dash. Length 0 marks an unsupported character.
  function automatic logic [7:0] code_rom(input logic [7:0] c);
    logic [7:0] uc;
    uc = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    case (uc)
      8'h41:   code_rom = {3'd2, 5'b00001};
      8'h42:   code_rom = {3'd4, 5'b01000};
      8'h43:   code_rom = {3'd4, 5'b01010};
      8'h44:   code_rom = {3'd3, 5'b00100};
      8'h45:   code_rom = {3'd1, 5'b00000};
      8'h46:   code_rom = {3'd4, 5'b00010};
      8'h47:   code_rom = {3'd3, 5'b00110};
      8'h48:   code_rom = {3'd4, 5'b00000};
      8'h49:   code_rom = {3'd2, 5'b00000};
      8'h4a:   code_rom = {3'd4, 5'b00111};
      8'h4b:   code_rom = {3'd3, 5'b00101};
      8'h4c:   code_rom = {3'd4, 5'b00100};
      8'h4d:   code_rom = {3'd2, 5'b00011};
      8'h4e:   code_rom = {3'd2, 5'b00010};
      8'h4f:   code_rom = {3'd3, 5'b00111};
      8'h50:   code_rom = {3'd4, 5'b00110};
      8'h51:   code_rom = {3'd4, 5'b01101};
      8'h52:   code_rom = {3'd3, 5'b00010};
      8'h53:   code_rom = {3'd3, 5'b00000};
      8'h54:   code_rom = {3'd1, 5'b00001};
      8'h55:   code_rom = {3'd3, 5'b00001};
      8'h56:   code_rom = {3'd4, 5'b00001};
      8'h57:   code_rom = {3'd3, 5'b00011};
      8'h58:   code_rom = {3'd4, 5'b01001};
      8'h59:   code_rom = {3'd4, 5'b01011};
      8'h5a:   code_rom = {3'd4, 5'b01100};
      8'h30:   code_rom = {3'd5, 5'b11111};
      8'h31:   code_rom = {3'd5, 5'b01111};
      8'h32:   code_rom = {3'd5, 5'b00111};
      8'h33:   code_rom = {3'd5, 5'b00011};
      8'h34:   code_rom = {3'd5, 5'b00001};
      8'h35:   code_rom = {3'd5, 5'b00000};
      8'h36:   code_rom = {3'd5, 5'b10000};
      8'h37:   code_rom = {3'd5, 5'b11000};
      8'h38:   code_rom = {3'd5, 5'b11100};
      8'h39:   code_rom = {3'd5, 5'b11110};
      default: code_rom = 8'h00;
    endcase
  endfunction

  logic [7:0]  code;
  logic [2:0]  code_len;
  logic [4:0]  pat_al;
  logic        is_space;
  logic [33:0] u_in;
  logic [33:0] u_in3;
  logic [33:0] u_in4;
  logic [33:0] unit3;
  logic        accept;

  always_comb begin
    code     = code_rom(char_in);
    code_len = code[7:5];
    // Left-align so the current element is always pat[4].
    pat_al   = code[4:0] << (3'd5 - code_len);
    is_space = (char_in == 8'h20);
    u_in     = (unit_cycles == 32'd0) ? 34'd1 : {2'b00, unit_cycles};
    u_in3    = (u_in << 1) + u_in;
    u_in4    = u_in << 2;
    unit3    = (unit << 1) + unit;
  end

  assign char_ready = (state == StIdle) && !rst && !abort;
  assign accept     = char_valid && char_ready;

  always_ff @(posedge clk) begin
    dot_pulse  <= 1'b0;
    dash_pulse <= 1'b0;
    done       <= 1'b0;
    bad_char   <= 1'b0;
    if (rst) begin
      state   <= StIdle;
      key_out <= 1'b0;
      cnt     <= '0;
      unit    <= '0;
      pat     <= '0;
      left    <= '0;
    end else if (abort) begin
      state   <= StIdle;
      key_out <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            unit <= u_in;
            if (is_space) begin
              state <= StWord;
              cnt   <= u_in4 - 34'd1;
            end else if (code_len != 3'd0) begin
              state      <= StMark;
              key_out    <= 1'b1;
              pat        <= pat_al;
              left       <= code_len;
              dot_pulse  <= !pat_al[4];
              dash_pulse <= pat_al[4];
              cnt        <= (pat_al[4] ? u_in3 : u_in) - 34'd1;
            end else begin
              state    <= StBad;
              bad_char <= 1'b1;
            end
          end
        end
        StMark: begin
          if (cnt != 34'd0) begin
            cnt <= cnt - 34'd1;
          end else begin
            key_out <= 1'b0;
            if (left > 3'd1) begin
              state <= StEgap;
              cnt   <= unit - 34'd1;
              pat   <= pat << 1;
              left  <= left - 3'd1;
            end else begin
              state <= StLgap;
              cnt   <= unit3 - 34'd1;
              left  <= 3'd0;
            end
          end
        end
        StEgap: begin
          if (cnt != 34'd0) begin
            cnt <= cnt - 34'd1;
          end else begin
            state      <= StMark;
            key_out    <= 1'b1;
            dot_pulse  <= !pat[4];
            dash_pulse <= pat[4];
            cnt        <= (pat[4] ? unit3 : unit) - 34'd1;
          end
        end
        StLgap, StWord: begin
          if (cnt != 34'd0) begin
            cnt <= cnt - 34'd1;
          end else begin
            state <= StIdle;
            done  <= 1'b1;
          end
        end
        StBad: begin
          state <= StIdle;
        end
        default: begin
          state   <= StIdle;
          key_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_tx_encoder.sv
// Scoreboard bench for morse_tx_encoder: expected per-cycle output vectors are queued at
// each handshake from a Morse string table and compared cycle by cycle.
module tb_morse_tx_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [31:0] unit_cycles = 32'd1;
  logic        abort = 1'b0;
  logic        key_out, dot_pulse, dash_pulse, done, bad_char;

  morse_tx_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .unit_cycles(unit_cycles),
    .abort      (abort),
    .key_out    (key_out),
    .dot_pulse  (dot_pulse),
    .dash_pulse (dash_pulse),
    .done       (done),
    .bad_char   (bad_char)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Vector layout: {char_ready, key_out, dot_pulse, dash_pulse, done, bad_char}
  logic [5:0] exp_q[$];
  logic [5:0] mon_exp;
  bit         mon_en = 1'b0;
  int         n_total = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic string morse_of(input logic [7:0] c);
    case (c)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      default: return "";
    endcase
  endfunction

  task automatic push_trace(input logic [7:0] c, input int unsigned unit);
    int unsigned u;
    logic [7:0]  uc;
    string       m;
    u  = (unit == 0) ? 1 : unit;
    uc = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    if (uc == 8'h20) begin
      repeat (4 * u) exp_q.push_back(6'b000000);
      exp_q.push_back(6'b100010);
      return;
    end
    m = morse_of(uc);
    if (m.len() == 0) begin
      exp_q.push_back(6'b000001);
      return;
    end
    for (int i = 0; i < m.len(); i++) begin
      bit          dash;
      int unsigned d;
      dash = (m[i] == 8'h2d);
      d    = dash ? 3 * u : u;
      for (int k = 0; k < int'(d); k++) begin
        if (k == 0) exp_q.push_back(dash ? 6'b010100 : 6'b011000);
        else        exp_q.push_back(6'b010000);
      end
      if (i < m.len() - 1) repeat (u) exp_q.push_back(6'b000000);
    end
    repeat (3 * u) exp_q.push_back(6'b000000);
    exp_q.push_back(6'b100010);
  endtask

  // Entered and left at posedge+1; char_valid stays high afterwards only when hold is set.
  task automatic send(input logic [7:0] c, input int unsigned unit, input bit hold,
                      output int unsigned acc_cyc);
    char_in     = c;
    unit_cycles = unit;
    char_valid  = 1'b1;
    acc_cyc     = 0;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (char_ready) begin
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        push_trace(c, unit);
        if (!hold) char_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", 64'd0, 64'd1);
    char_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    do begin
      @(posedge clk);
      w++;
    end while (exp_q.size() != 0 && w < 3000);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0) mon_exp = exp_q.pop_front();
      else                   mon_exp = {(!rst && !abort), 5'b00000};
      chk($sformatf("out@%0d", cyc),
          {char_ready, key_out, dot_pulse, dash_pulse, done, bad_char}, mon_exp);
    end
  end

  int unsigned t0, t1;

  initial begin
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    send("E", 4, 1'b0, t0);  drain();
    send("a", 2, 1'b0, t0);  drain();

    send("0", 1, 1'b1, t0);
    send(" ", 1, 1'b0, t1);
    chk("b2b_accept_gap", 64'(t1 - t0), 64'd23);
    drain();

    send("#", 5, 1'b0, t0);  drain();
    send("T", 0, 1'b0, t0);  drain();
    send("K", 3, 1'b0, t0);  drain();

    // Abort during the dash of 'N' at T+12.
    send("N", 8, 1'b0, t0);
    repeat (11) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    exp_q.delete();
    repeat (40) @(posedge clk);
    #1;

    // Abort together with char_valid in idle: no handshake.
    char_in = "E"; unit_cycles = 2; char_valid = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 char_valid = 1'b0; abort = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Unit change in flight must not affect the character.
    send("S", 3, 1'b0, t0);
    unit_cycles = 10;
    drain();

    // Reset mid-mark.
    send("O", 4, 1'b0, t0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    send("5", 1, 1'b0, t0);  drain();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
